usb_token_generator: RTL



---
 rtl/usb_pkg.sv | 24 ++
 rtl/usb_crc5.sv | 26 ++
 rtl/usb_token_generator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB protocol constants: PIDs, token type encoding and CRC5 parameters.
package usb_pkg;

  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_SOF   = 8'hA5;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [1:0] {
    TOK_SETUP = 2'b00,
    TOK_IN    = 2'b01,
    TOK_OUT   = 2'b10,
    TOK_SOF   = 2'b11
  } token_type_e;

  localparam logic [4:0] CRC5_POLY = 5'h05;
  localparam logic [4:0] CRC5_INIT = 5'h1F;

endpackage

// File: rtl/usb_crc5.sv
// Combinational USB CRC5 over an 11-bit token field; output is bit-reversed so
// that sending it LSB-first puts the CRC on the wire MSB-first.
module usb_crc5
  import usb_pkg::*;
(
  input  logic [10:0] data,
  output logic [4:0]  crc_field
);

  logic [4:0] crc;
  logic       fb;

  always_comb begin
    crc       = CRC5_INIT;
    fb        = 1'b0;
    crc_field = '0;
    for (int i = 0; i < 11; i++) begin
      fb  = data[i] ^ crc[4];
      crc = {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    end
    for (int i = 0; i < 5; i++) begin
      crc_field[i] = ~crc[4-i];
    end
  end

endmodule

// File: rtl/usb_token_generator.sv
// Host-side USB token emitter: captures one request, streams PID/TOK1/TOK2 over UTMI,
// waits the inter-packet gap and pulses token_done. SOF tokens need USB_TOKEN_SOF_EN.
module usb_token_generator
  import usb_pkg::*;
#(
  parameter int IPG_CYCLES = 4,
  parameter int TX_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        token_start,
  input  logic [1:0]  token_type,
  input  logic [6:0]  token_addr,
  input  logic [3:0]  token_endp,
  input  logic [10:0] sof_frame,
  output logic        token_ready,
  output logic        token_done,
  output logic        token_err,
  output logic [7:0]  utmi_tx_data,
  output logic        utmi_tx_valid,
  input  logic        utmi_tx_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PID  = 3'd1;
  localparam logic [2:0] S_TOK1 = 3'd2;
  localparam logic [2:0] S_TOK2 = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

`ifdef USB_TOKEN_SOF_EN
  localparam logic SOF_EN = 1'b1;
`else
  localparam logic SOF_EN = 1'b0;
`endif

  localparam logic [9:0] TIMEOUT_LAST = 10'(TX_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST     = 8'(IPG_CYCLES - 1);

  logic [2:0]  state;
  logic [9:0]  wait_cnt;
  logic [7:0]  gap_cnt;
  logic        err_q;
  logic        accept;
  logic        is_sof;
  logic [10:0] crc_data;
  logic [4:0]  crc_field;
  logic [7:0]  pid_nxt, tok1_nxt, tok2_nxt;
  logic [7:0]  pid_p0, tok1_p0, tok2_p0;

  assign accept   = (state == S_IDLE) && token_start;
  assign is_sof   = (token_type == TOK_SOF);
  assign crc_data = is_sof ? sof_frame : {token_endp, token_addr};

  usb_crc5 u_crc5 (
    .data      (crc_data),
    .crc_field (crc_field)
  );

  always_comb begin
    pid_nxt  = PID_SETUP;
    tok1_nxt = {token_endp[0], token_addr};
    tok2_nxt = {crc_field, token_endp[3:1]};
    case (token_type)
      TOK_SETUP: pid_nxt = PID_SETUP;
      TOK_IN:    pid_nxt = PID_IN;
      TOK_OUT:   pid_nxt = PID_OUT;
      default: begin
        pid_nxt  = PID_SOF;
        tok1_nxt = sof_frame[7:0];
        tok2_nxt = {crc_field, sof_frame[10:8]};
      end
    endcase
  end

  // Capture stage: packet bytes frozen at acceptance, immune to later input changes
  always_ff @(posedge clk) begin
    if (accept) begin
      pid_p0  <= pid_nxt;
      tok1_p0 <= tok1_nxt;
      tok2_p0 <= tok2_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (token_start) begin
            wait_cnt <= '0;
            gap_cnt  <= '0;
            if (is_sof && !SOF_EN) begin
              state <= S_DONE;
              err_q <= 1'b1;
            end else begin
              state <= S_PID;
              err_q <= 1'b0;
            end
          end
        end
        S_PID, S_TOK1, S_TOK2: begin
          if (utmi_tx_ready) begin
            wait_cnt <= '0;
            state    <= (state == S_PID) ? S_TOK1 : (state == S_TOK1) ? S_TOK2 : S_GAP;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            // PHY stalled too long: abandon the packet and skip the gap
            state <= S_DONE;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_DONE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output stage: decoded from the registered state
  always_comb begin
    utmi_tx_valid = 1'b0;
    utmi_tx_data  = 8'h00;
    case (state)
      S_PID:  begin utmi_tx_valid = 1'b1; utmi_tx_data = pid_p0;  end
      S_TOK1: begin utmi_tx_valid = 1'b1; utmi_tx_data = tok1_p0; end
      S_TOK2: begin utmi_tx_valid = 1'b1; utmi_tx_data = tok2_p0; end
      default: ;
    endcase
  end

  assign token_ready = (state == S_IDLE);
  assign token_done  = (state == S_DONE);
  assign token_err   = token_done && err_q;

endmodule
